single_tx_uart: RTL

// Serialises one byte per frame onto a UART line; upstream partner of SingleRxUART (its txd drives rxd).

---
 rtl/single_tx_uart.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/single_tx_uart.sv
// UART transmitter: one byte per frame via valid/ready handshake.
// Start bit, 8 data bits, optional parity, 1 or 2 stop bits.
module single_tx_uart #(
    parameter int    CLOCK     = 10_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int DIV = (CLOCK + BAUD / 2) / BAUD;
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam bit PAR_EN = (PARITY != "NO");
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam bit MSB_FIRST = (FIRST_BIT == "MSB");
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("single_tx_uart: DIV must be at least 2");
    end
    if (PARITY != "NO" && PARITY != "EVEN" && PARITY != "ODD") begin : g_bad_par
        $error("single_tx_uart: PARITY must be NO, EVEN or ODD");
    end
    if (FIRST_BIT != "LSB" && FIRST_BIT != "MSB") begin : g_bad_order
        $error("single_tx_uart: FIRST_BIT must be LSB or MSB");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("single_tx_uart: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          next_bit;
    logic [7:0]    shifted;

    assign next_bit = MSB_FIRST ? shreg[7] : shreg[0];
    assign shifted  = MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        par_bit  <= PAR_ODD ? ~^tx_data : ^tx_data;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= S_START;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                default: begin
                    // every non-idle bit lasts DIV clocks; act on the wrap edge
                    if (cnt != LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        unique case (state)
                            S_START: begin
                                txd     <= next_bit;
                                shreg   <= shifted;
                                bit_cnt <= '0;
                                state   <= S_DATA;
                            end
                            S_DATA: begin
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    if (PAR_EN) begin
                                        txd   <= par_bit;
                                        state <= S_PARITY;
                                    end else begin
                                        txd   <= 1'b1;
                                        state <= S_STOP;
                                    end
                                end else begin
                                    txd     <= next_bit;
                                    shreg   <= shifted;
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            S_PARITY: begin
                                txd     <= 1'b1;
                                bit_cnt <= '0;
                                state   <= S_STOP;
                            end
                            S_STOP: begin
                                txd <= 1'b1;
                                if (bit_cnt == STOP_LAST) begin
                                    done     <= 1'b1;
                                    busy     <= 1'b0;
                                    tx_ready <= 1'b1;
                                    state    <= S_IDLE;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
